// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the memory access unit:
//   mem_size_e  - MemWrite store-size codes (also reused as the access size)
//   load_type_e - LoadType load-format codes
//   mau_state_e - memory access FSM states
// Helpers:
//   load_size()     - access size implied by a LoadType code
//   is_misaligned() - alignment check for a given size and address low bits
// ----------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic [1:0] {
      MW_NONE = 2'b00,
      MW_BYTE = 2'b01,
      MW_HALF = 2'b10,
      MW_WORD = 2'b11
   } mem_size_e;

   typedef enum logic [2:0] {
      LT_LB  = 3'b000,
      LT_LH  = 3'b001,
      LT_LW  = 3'b010,
      LT_LBU = 3'b100,
      LT_LHU = 3'b101
   } load_type_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mau_state_e;

   // Unlisted load codes behave as a word load.
   function automatic logic [1:0] load_size(input logic [2:0] lt);
      case (lt)
         LT_LB, LT_LBU: return MW_BYTE;
         LT_LH, LT_LHU: return MW_HALF;
         default:       return MW_WORD;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      case (size)
         MW_HALF: return addr_lo[0];
         MW_WORD: return (addr_lo != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ----------------------------------------------------------------------------
// mem_access_unit_if
// Memory-side bus between the access unit (master) and the memory (slave).
//   mem_req/mem_we       request and write enable (master -> slave)
//   mem_addr             word-aligned address
//   mem_wdata/mem_wstrb  lane-replicated store data and byte strobes
//   mem_ready            one-cycle completion pulse (slave -> master)
//   mem_rdata            read word, valid with mem_ready
// ----------------------------------------------------------------------------
interface mem_access_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/load_formatter.sv
// ----------------------------------------------------------------------------
// load_formatter
// Combinational load-result formatting: picks the byte or half lane selected
// by the address low bits and sign- or zero-extends it to 32 bits.
//   i_rdata      read word from memory
//   i_addr_lo    effective address bits [1:0]
//   i_load_type  LoadType code (unlisted codes pass the word through)
//   o_data       formatted 32-bit load value
// ----------------------------------------------------------------------------
module load_formatter
   import cpu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_load_type,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'b00:   w_byte = i_rdata[7:0];
         2'b01:   w_byte = i_rdata[15:8];
         2'b10:   w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
   end

   assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_data = i_rdata;
      case (i_load_type)
         LT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         LT_LBU:  o_data = {24'h000000, w_byte};
         LT_LH:   o_data = {{16{w_half[15]}}, w_half};
         LT_LHU:  o_data = {16'h0000, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store unit. Turns an EX/MEM access into a registered
// request on the memory bus, stalls the pipeline until mem_ready, formats
// store data/strobes and load results, and flags misaligned accesses and
// bus timeouts.
//   clk, rst              clock; asynchronous active-high reset
//   flush                 squashes the current access result
//   MemRead/MemWrite      load request / store size
//   LoadType              load format
//   Read_data_2, rd_data  store data, effective address
//   bus                   memory bus (master side)
//   stall                 holds upstream stages and EX/MEM
//   load_data, mem_done   formatted load result and completion pulse
//   misaligned, bus_err   exception pulses
// ----------------------------------------------------------------------------
module mem_access_unit
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               MemRead,
   input  logic [1:0]         MemWrite,
   input  logic [2:0]         LoadType,
   input  logic [31:0]        Read_data_2,
   input  logic [31:0]        rd_data,
   mem_access_unit_if.master  bus,
   output logic               stall,
   output logic [31:0]        load_data,
   output logic               mem_done,
   output logic               misaligned,
   output logic               bus_err
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   mau_state_e  r_state,      w_state_next;
   logic [7:0]  r_cnt,        w_cnt_next;
   logic        r_squash,     w_squash_next;
   logic        r_mem_req,    w_mem_req_next;
   logic        r_mem_we,     w_mem_we_next;
   logic [31:0] r_mem_addr,   w_mem_addr_next;
   logic [31:0] r_mem_wdata,  w_mem_wdata_next;
   logic [3:0]  r_mem_wstrb,  w_mem_wstrb_next;
   logic [1:0]  r_addr_lo,    w_addr_lo_next;
   logic [2:0]  r_load_type,  w_load_type_next;

   logic        w_is_store;
   logic        w_active;
   logic [1:0]  w_size;
   logic        w_misaligned;
   logic [31:0] w_wdata;
   logic [3:0]  w_wstrb;
   logic [31:0] w_fmt_data;
   logic        w_squash_eff;

   // A store takes priority over a simultaneous load request.
   assign w_is_store   = (MemWrite != MW_NONE);
   assign w_active     = w_is_store | MemRead;
   assign w_size       = w_is_store ? MemWrite : load_size(LoadType);
   assign w_misaligned = w_active & is_misaligned(w_size, rd_data[1:0]);

   // Store data replicated across all lanes; strobes pick the live lanes.
   always_comb begin
      w_wdata = Read_data_2;
      w_wstrb = 4'b0000;
      case (MemWrite)
         MW_BYTE: begin
            w_wdata = {4{Read_data_2[7:0]}};
            w_wstrb = 4'b0001 << rd_data[1:0];
         end
         MW_HALF: begin
            w_wdata = {2{Read_data_2[15:0]}};
            w_wstrb = rd_data[1] ? 4'b1100 : 4'b0011;
         end
         MW_WORD: w_wstrb = 4'b1111;
         default: ;
      endcase
   end

   // A flush on the completion cycle squashes that result too.
   assign w_squash_eff = r_squash | flush;

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_squash_next    = r_squash;
      w_mem_req_next   = r_mem_req;
      w_mem_we_next    = r_mem_we;
      w_mem_addr_next  = r_mem_addr;
      w_mem_wdata_next = r_mem_wdata;
      w_mem_wstrb_next = r_mem_wstrb;
      w_addr_lo_next   = r_addr_lo;
      w_load_type_next = r_load_type;
      stall            = 1'b0;
      mem_done         = 1'b0;
      misaligned       = 1'b0;
      bus_err          = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cnt_next    = 8'd0;
            w_squash_next = 1'b0;
            if (w_active && !flush) begin
               if (w_misaligned) begin
                  misaligned = 1'b1;
               end else begin
                  stall            = 1'b1;
                  w_mem_req_next   = 1'b1;
                  w_mem_we_next    = w_is_store;
                  w_mem_addr_next  = {rd_data[31:2], 2'b00};
                  w_mem_wdata_next = w_wdata;
                  w_mem_wstrb_next = w_wstrb;
                  w_addr_lo_next   = rd_data[1:0];
                  w_load_type_next = LoadType;
                  w_state_next     = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            stall         = !bus.mem_ready;
            w_cnt_next    = r_cnt + 8'd1;
            w_squash_next = w_squash_eff;
            if (bus.mem_ready) begin
               mem_done       = !w_squash_eff;
               w_mem_req_next = 1'b0;
               w_squash_next  = 1'b0;
               w_state_next   = ST_IDLE;
            end else if (r_cnt == TIMEOUT_LAST) begin
               bus_err        = !w_squash_eff;
               w_mem_req_next = 1'b0;
               w_squash_next  = 1'b0;
               w_state_next   = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase

      // Combinational outputs must read 0 while reset is held, even if an
      // access is still being presented on the pipeline inputs.
      if (rst) begin
         stall      = 1'b0;
         mem_done   = 1'b0;
         misaligned = 1'b0;
         bus_err    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 8'd0;
         r_squash    <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_mem_wstrb <= 4'd0;
         r_addr_lo   <= 2'd0;
         r_load_type <= 3'd0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_squash    <= w_squash_next;
         r_mem_req   <= w_mem_req_next;
         r_mem_we    <= w_mem_we_next;
         r_mem_addr  <= w_mem_addr_next;
         r_mem_wdata <= w_mem_wdata_next;
         r_mem_wstrb <= w_mem_wstrb_next;
         r_addr_lo   <= w_addr_lo_next;
         r_load_type <= w_load_type_next;
      end
   end

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_wstrb = r_mem_wstrb;

   load_formatter u_load_formatter (
      .i_rdata     (bus.mem_rdata),
      .i_addr_lo   (r_addr_lo),
      .i_load_type (r_load_type),
      .o_data      (w_fmt_data)
   );

   assign load_data = mem_done ? w_fmt_data : 32'd0;

endmodule
